// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C init sequencer and the byte-level I2C master.
// I2C_SEQ_READBACK_EN adds the readback-verify states to the state enum.
package i2c_seq_pkg;

    localparam logic [7:0] END_MARKER = 8'hFF;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        WAIT_RESP,
        GAP,
        DONE,
        ERROR
`ifdef I2C_SEQ_READBACK_EN
        ,
        RB_ISSUE,
        RB_WAIT
`endif
    } seq_state_e;

    // Field is reg_addr because 'reg' is a reserved word.
    typedef struct packed {
        logic [6:0] dev;
        logic       rw;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } i2c_cmd_t;

endpackage

// File: rtl/i2c_seq_gap_timer.sv
// Loadable down-counter with a zero flag; paces inter-write gaps and bus-free time.
module i2c_seq_gap_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_low,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst_low) begin
        if (!rst_low) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a register-write table and issues one I2C write per entry, with NACK retry and gaps.
// Define I2C_SEQ_READBACK_EN to read back and verify every acked write.
module i2c_init_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int         NUM_ENTRIES = 16,
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         MAX_RETRY   = 3,
    parameter int         GAP_CYCLES  = 1000,
    parameter int         IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_low,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [7:0]       tbl_reg,
    input  logic [7:0]       tbl_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [6:0]       cmd_dev,
    output logic             cmd_rw,
    output logic [7:0]       cmd_reg,
    output logic [7:0]       cmd_data,
    input  logic             resp_valid,
    input  logic             resp_nack,
    input  logic [7:0]       resp_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_idx
);

    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [7:0]       reg_q, reg_d, data_q, data_d;
    logic             done_q, done_d, error_q, error_d;
    logic             gap_load, gap_dec, gap_zero, pass, fail, issuing;
    i2c_cmd_t         cmd;

    i2c_seq_gap_timer #(.W(GAP_W)) u_gap (
        .clk        (clk),
        .rst_low    (rst_low),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        reg_d     = reg_q;
        data_d    = data_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        pass      = 1'b0;
        fail      = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: if (start) begin
                state_d   = FETCH;
                idx_d     = '0;
                retry_d   = '0;
                done_d    = 1'b0;
                error_d   = 1'b0;
                err_idx_d = '0;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                reg_d  = tbl_reg;
                data_d = tbl_data;
                if (tbl_reg == END_MARKER) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: if (cmd_ready) state_d = WAIT_RESP;
            WAIT_RESP: if (resp_valid) begin
                if (resp_nack) fail = 1'b1;
`ifdef I2C_SEQ_READBACK_EN
                else           state_d = RB_ISSUE;
`else
                else           pass = 1'b1;
`endif
            end
`ifdef I2C_SEQ_READBACK_EN
            RB_ISSUE: if (cmd_ready) state_d = RB_WAIT;
            RB_WAIT: if (resp_valid) begin
                if (resp_nack || resp_data != data_q) fail = 1'b1;
                else                                  pass = 1'b1;
            end
`endif
            GAP: begin
                if (!gap_zero) begin
                    gap_dec = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pass) begin
            state_d  = GAP;
            gap_load = 1'b1;
            retry_d  = '0;
        end
        // A failed attempt replays the latched entry from the write; no refetch.
        if (fail) begin
            if (retry_q == RTY_MAX) begin
                state_d   = ERROR;
                error_d   = 1'b1;
                err_idx_d = idx_q;
            end else begin
                retry_d = retry_q + RTY_W'(1);
                state_d = ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_low) begin
        if (!rst_low) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

`ifdef I2C_SEQ_READBACK_EN
    assign issuing = (state_q == ISSUE) || (state_q == RB_ISSUE);
`else
    assign issuing = (state_q == ISSUE);
    logic unused_resp_data;
    assign unused_resp_data = ^resp_data;
`endif

    // Payload is zero outside issue states so every output reads 0 out of reset.
    always_comb begin
        cmd = '0;
        if (issuing) begin
            cmd.dev      = DEV_ADDR;
            cmd.reg_addr = reg_q;
            cmd.data     = data_q;
`ifdef I2C_SEQ_READBACK_EN
            cmd.rw       = (state_q == RB_ISSUE);
`endif
        end
    end

    assign cmd_valid = issuing;
    assign cmd_dev   = cmd.dev;
    assign cmd_rw    = cmd.rw;
    assign cmd_reg   = cmd.reg_addr;
    assign cmd_data  = cmd.data;
    assign tbl_idx   = idx_q;
    assign busy      = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign done      = done_q;
    assign error     = error_q;
    assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer: 4-entry table, scripted I2C master responder.
module tb_i2c_init_sequencer;

    localparam int NE  = 4;
    localparam int IW  = 2;
    localparam int LAT = 2;
`ifdef I2C_SEQ_READBACK_EN
    localparam int TB_MAXR = 0;
`else
    localparam int TB_MAXR = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_low, start;
    logic [IW-1:0] tbl_idx, err_idx;
    logic [7:0]    tbl_reg, tbl_data;
    logic          cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]    cmd_dev;
    logic [7:0]    cmd_reg, cmd_data;
    logic          resp_valid, resp_nack;
    logic [7:0]    resp_data;
    logic          busy, done, error;

    always #5 clk = ~clk;

    i2c_init_sequencer #(
        .NUM_ENTRIES (NE),
        .DEV_ADDR    (7'h1A),
        .MAX_RETRY   (TB_MAXR),
        .GAP_CYCLES  (4)
    ) dut (
        .clk        (clk),
        .rst_low    (rst_low),
        .start      (start),
        .tbl_idx    (tbl_idx),
        .tbl_reg    (tbl_reg),
        .tbl_data   (tbl_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dev    (cmd_dev),
        .cmd_rw     (cmd_rw),
        .cmd_reg    (cmd_reg),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_nack  (resp_nack),
        .resp_data  (resp_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_idx    (err_idx)
    );

    logic [7:0] rom_reg [NE];
    logic [7:0] rom_dat [NE];
    assign tbl_reg  = rom_reg[tbl_idx];
    assign tbl_data = rom_dat[tbl_idx];

    logic [31:0] outs_v;
    assign outs_v = {cmd_valid, busy, done, error, cmd_rw, tbl_idx, err_idx,
                     cmd_dev, cmd_reg, cmd_data};

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Responder state, configured by the main thread before each sequence.
    int         stall_left, stall_seen, stall_chg, nack_left, rsp_cnt, acc_n, proto_bad;
    logic [7:0] nack_reg, rb_add, rd_now, last_wdata;
    logic       nack_now, acc_prev;
    logic [15:0] stall_pl;
    logic [7:0] acc_reg [16];
    logic [7:0] acc_dat [16];
    logic       acc_rw  [16];

    initial begin
        cmd_ready = 0; resp_valid = 0; resp_nack = 0; resp_data = 0;
        rsp_cnt = 0; acc_prev = 0; nack_now = 0; rd_now = 0; last_wdata = 0;
        forever begin
            @(negedge clk);
            resp_valid = 1'b0;
            resp_nack  = 1'b0;
            if (!rst_low) begin
                rsp_cnt = 0; cmd_ready = 0; acc_prev = 0;
            end else begin
                if (acc_prev && cmd_valid) proto_bad++;
                acc_prev = 1'b0;
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        resp_valid = 1'b1; resp_nack = nack_now; resp_data = rd_now;
                    end
                end
                if (cmd_valid && stall_left > 0) begin
                    if (stall_seen == 0) stall_pl = {cmd_reg, cmd_data};
                    else if ({cmd_reg, cmd_data} != stall_pl) stall_chg++;
                    stall_seen++;
                    stall_left--;
                    cmd_ready = 1'b0;
                end else begin
                    cmd_ready = cmd_valid;
                end
                if (cmd_valid && cmd_ready) begin
                    if (cmd_dev != 7'h1A) proto_bad++;
`ifndef I2C_SEQ_READBACK_EN
                    if (cmd_rw) proto_bad++;
`endif
                    if (acc_n < 16) begin
                        acc_reg[acc_n] = cmd_reg; acc_dat[acc_n] = cmd_data; acc_rw[acc_n] = cmd_rw;
                    end
                    acc_n++;
                    if (!cmd_rw) last_wdata = cmd_data;
                    nack_now = (cmd_reg == nack_reg) && (nack_left > 0);
                    if (nack_now) nack_left--;
                    rd_now   = last_wdata + rb_add;
                    acc_prev = 1'b1;
                    rsp_cnt  = LAT;
                end
            end
        end
    end

    task automatic clear_cfg();
        acc_n = 0; proto_bad = 0; stall_left = 0; stall_seen = 0; stall_chg = 0;
        nack_left = 0; nack_reg = 8'h00; rb_add = 8'h00;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int cyc);
        cyc = 0;
        while (busy && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        chk(tag, busy, 0);
    endtask

    task automatic chk_log(input string tag, input int n, input logic [63:0] regs,
                           input logic [63:0] dats);
        logic [63:0] gr, gd;
        gr = '0; gd = '0;
        for (int i = 0; i < n && i < 8; i++) begin
            gr[8*i +: 8] = acc_reg[i];
            gd[8*i +: 8] = acc_dat[i];
        end
        chk({tag, "_cnt"}, acc_n, n);
        chk({tag, "_regs"}, gr, regs);
        chk({tag, "_data"}, gd, dats);
        chk({tag, "_proto"}, proto_bad, 0);
    endtask

    initial begin
        int cyc, k;
        rom_reg[0] = 8'h01; rom_dat[0] = 8'h11;
        rom_reg[1] = 8'h02; rom_dat[1] = 8'h22;
        rom_reg[2] = 8'h03; rom_dat[2] = 8'h33;
        rom_reg[3] = 8'hFF; rom_dat[3] = 8'h00;
        rst_low = 1'b0; start = 1'b0;
        clear_cfg();
        #1;
        chk("reset_outs", outs_v, 0);
        #30;
        @(negedge clk); rst_low = 1'b1;
        @(negedge clk);
        chk("post_reset_outs", outs_v, 0);

`ifdef I2C_SEQ_READBACK_EN
        clear_cfg(); rb_add = 8'h01;
        pulse_start();
        wait_idle("rb_idle", cyc);
        chk_log("rb", 2, 64'h0101, 64'h1111);
        chk("rb_rw", {acc_rw[1], acc_rw[0]}, 2'b10);
        chk("rb_error", error, 1);
        chk("rb_err_idx", err_idx, 0);
        chk("rb_done", done, 0);
`else
        // Plain walk: 3 entries x (3 + 2 + 4) cycles, plus fetch/latch of the marker.
        clear_cfg();
        pulse_start();
        wait_idle("t1_idle", cyc);
        chk("t1_cycles", cyc, 29);
        chk_log("t1", 3, 64'h030201, 64'h332211);
        chk("t1_flags", {done, error, busy}, 3'b100);

        clear_cfg(); nack_reg = 8'h02; nack_left = 2;
        pulse_start();
        wait_idle("t2_idle", cyc);
        chk_log("t2", 5, 64'h03_02_02_02_01, 64'h33_22_22_22_11);
        chk("t2_flags", {done, error}, 2'b10);

        clear_cfg(); nack_reg = 8'h03; nack_left = 99;
        pulse_start();
        wait_idle("t3_idle", cyc);
        chk_log("t3", 6, 64'h03_03_03_03_02_01, 64'h33_33_33_33_22_11);
        chk("t3_flags", {done, error}, 2'b01);
        chk("t3_err_idx", err_idx, 2);

        clear_cfg(); stall_left = 10;
        pulse_start();
        wait_idle("t4_idle", cyc);
        chk("t4_stall_seen", stall_seen, 10);
        chk("t4_stall_chg", stall_chg, 0);
        chk_log("t4", 3, 64'h030201, 64'h332211);
        chk("t4_flags", {done, error}, 2'b10);

        clear_cfg();
        pulse_start();
        k = 0;
        while (acc_n < 2 && k < 200) begin
            k++;
            @(negedge clk);
        end
        chk("t5_reach_entry1", acc_n, 2);
        @(posedge clk); #2;
        chk("t5_pre_busy", {busy, cmd_valid, tbl_idx}, {1'b1, 1'b0, 2'd1});
        rst_low = 1'b0;
        #1;
        chk("t5_async_outs", outs_v, 0);
        repeat (3) @(negedge clk);
        rst_low = 1'b1;
        clear_cfg();
        pulse_start();
        wait_idle("t5_idle", cyc);
        chk_log("t5", 3, 64'h030201, 64'h332211);
        chk("t5_flags", {done, error}, 2'b10);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
